decode_regfile_stage: RTL and testbench



---
 rtl/rv_pkg.sv | 38 +++
 rtl/decode_regfile_stage_if.sv | 36 +++
 rtl/rv_regfile.sv | 54 +++++
 rtl/decode_regfile_stage.sv | 84 ++++++++
 tb/tb_decode_regfile_stage.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_pkg
//  Description : Shared RV32 constants for the decode / operand-fetch stage:
//                data widths, the canonical NOP, opcode and field positions.
//  Revision    : 1.0  initial release
// ============================================================================
package rv_pkg;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int RA_W  = 5;

   // ADDI x0,x0,0 -- what the ALU sees whenever the stage is empty
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [6:0] OP_IMM = 7'b0010011;

   // Instruction field positions
   localparam int RD_LSB  = 7;
   localparam int RD_MSB  = 11;
   localparam int F3_LSB  = 12;
   localparam int F3_MSB  = 14;
   localparam int RS1_LSB = 15;
   localparam int RS1_MSB = 19;
   localparam int IMM_LSB = 20;
   localparam int IMM_MSB = 31;

   function automatic logic [RA_W-1:0] rs1_of(input logic [31:0] instr);
      return instr[RS1_MSB:RS1_LSB];
   endfunction

   function automatic logic [RA_W-1:0] rd_of(input logic [31:0] instr);
      return instr[RD_MSB:RD_LSB];
   endfunction

endpackage
`default_nettype wire

// File: rtl/decode_regfile_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_regfile_stage_if
//  Description : Fetch-side handshake, ALU-side output bus, writeback port
//                and flush for the decode / register-fetch stage.
//                slave = the stage, master = its surroundings.
//  Revision    : 1.0  initial release
// ============================================================================
interface decode_regfile_stage_if;
   import rv_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_instr;
   logic [XLEN-1:0] out_rs1_val;
   logic [RA_W-1:0] out_rd;
   logic            wb_valid;
   logic [RA_W-1:0] wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            flush;

   modport slave (
      input  in_valid, in_instr, out_ready, wb_valid, wb_rd, wb_data, flush,
      output in_ready, out_valid, out_instr, out_rs1_val, out_rd
   );

   modport master (
      output in_valid, in_instr, out_ready, wb_valid, wb_rd, wb_data, flush,
      input  in_ready, out_valid, out_instr, out_rs1_val, out_rd
   );

endinterface
`default_nettype wire

// File: rtl/rv_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : rv_regfile
//  Description : 32 x XLEN integer register file. One combinational read
//                port (x0 reads zero, same-cycle write is bypassed to the
//                read) and one synchronous write port; async active-low clear.
//  Revision    : 1.0  initial release
// ============================================================================
module rv_regfile
   import rv_pkg::*;
(
   input  wire logic            clk,
   input  wire logic            rst_n,
   input  wire logic [RA_W-1:0] rd_addr,
   output logic      [XLEN-1:0] rd_data,
   input  wire logic            wr_en,
   input  wire logic [RA_W-1:0] wr_addr,
   input  wire logic [XLEN-1:0] wr_data
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];

   // Read port: x0 is zero, a write in this cycle wins over the stored value
   always_comb begin
      rd_data = regs_q[rd_addr];
      if (rd_addr == '0) begin
         rd_data = '0;
      end else if (wr_en && (wr_addr == rd_addr)) begin
         rd_data = wr_data;
      end
   end

   // Next register contents: writes to x0 are dropped
   always_comb begin
      regs_d = regs_q;
      if (wr_en && (wr_addr != '0)) begin
         regs_d[wr_addr] = wr_data;
      end
   end

   // Register array with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/decode_regfile_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_regfile_stage
//  Description : Decode / operand-fetch stage ahead of the I-type ALU.
//                Registers the instruction with its rs1 operand, keeps the
//                held operand fresh across stalls, and feeds ALU results
//                back into the register file.
//  Revision    : 1.0  initial release
// ============================================================================
module decode_regfile_stage
   import rv_pkg::*;
(
   input  wire logic               clk,
   input  wire logic               rst_n,
   decode_regfile_stage_if.slave   bus
);

   logic            out_valid_q,   out_valid_d;
   logic [31:0]     out_instr_q,   out_instr_d;
   logic [XLEN-1:0] out_rs1_val_q, out_rs1_val_d;
   logic [XLEN-1:0] rf_rd_data;
   logic            in_ready;
   logic            accept;
   logic            wb_hits_held;

   rv_regfile u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_addr (rs1_of(bus.in_instr)),
      .rd_data (rf_rd_data),
      .wr_en   (bus.wb_valid),
      .wr_addr (bus.wb_rd),
      .wr_data (bus.wb_data)
   );

   // Handshake: accept whenever the output slot is free or being drained
   always_comb begin
      in_ready     = !bus.flush && (!out_valid_q || bus.out_ready);
      accept       = bus.in_valid && in_ready;
      wb_hits_held = bus.wb_valid && (bus.wb_rd != '0)
                     && (bus.wb_rd == rs1_of(out_instr_q));
   end

   // Output register next state: flush > accept > drain > stall refresh
   always_comb begin
      out_valid_d   = out_valid_q;
      out_instr_d   = out_instr_q;
      out_rs1_val_d = out_rs1_val_q;
      if (bus.flush) begin
         out_valid_d = 1'b0;
         out_instr_d = NOP_INSTR;
      end else if (accept) begin
         out_valid_d   = 1'b1;
         out_instr_d   = bus.in_instr;
         out_rs1_val_d = rf_rd_data;
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end else if (out_valid_q && wb_hits_held) begin
         // stalled: a writeback to our rs1 must not leave the operand stale
         out_rs1_val_d = bus.wb_data;
      end
   end

   // Output register with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q   <= 1'b0;
         out_instr_q   <= NOP_INSTR;
         out_rs1_val_q <= '0;
      end else begin
         out_valid_q   <= out_valid_d;
         out_instr_q   <= out_instr_d;
         out_rs1_val_q <= out_rs1_val_d;
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_instr   = out_instr_q;
   assign bus.out_rs1_val = out_rs1_val_q;
   assign bus.out_rd      = rd_of(out_instr_q);

endmodule
`default_nettype wire

// File: tb/tb_decode_regfile_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_regfile_stage
//  Description : Self-checking bench for decode_regfile_stage. Accepted
//                instructions are pushed with their expected operand into a
//                scoreboard queue and popped when the ALU side takes them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decode_regfile_stage;
   import rv_pkg::*;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] rs1;
   } exp_t;

   logic clk;
   logic rst_n;
   decode_regfile_stage_if bus ();

   decode_regfile_stage u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   exp_t        sb[$];
   logic [31:0] m_regs [32];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
      logic [11:0] i12;
      logic [4:0]  a;
      logic [4:0]  d;
      i12 = imm[11:0];
      a   = rs1[4:0];
      d   = rd[4:0];
      return {i12, a, 3'b000, d, 7'b0010011};
   endfunction

   function automatic logic [31:0] operand(input logic [4:0] a, input logic wv,
                                           input logic [4:0] wrd, input logic [31:0] wd);
      if (a == 5'd0) return 32'd0;
      if (wv && wrd == a) return wd;
      return m_regs[a];
   endfunction

   task automatic model_reset();
      sb.delete();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
   endtask

   // One clock cycle: drive at the falling edge, check, update the model, advance
   task automatic tick(input logic iv, input logic [31:0] ii, input logic ordy,
                       input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic fl);
      logic exp_ready;
      exp_t e;
      bus.in_valid  = iv;
      bus.in_instr  = ii;
      bus.out_ready = ordy;
      bus.wb_valid  = wv;
      bus.wb_rd     = wrd;
      bus.wb_data   = wd;
      bus.flush     = fl;
      #1;
      exp_ready = !fl && (sb.size() == 0 || ordy);
      check("in_ready",  {31'd0, bus.in_ready},  {31'd0, exp_ready});
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, sb.size() != 0});
      if (sb.size() != 0 && ordy) begin
         e = sb.pop_front();
         check("xfer_instr", bus.out_instr,   e.instr);
         check("xfer_rs1",   bus.out_rs1_val, e.rs1);
         check("xfer_rd",    {27'd0, bus.out_rd}, {27'd0, e.instr[11:7]});
      end
      if (fl) begin
         sb.delete();
      end else if (sb.size() != 0 && wv && wrd != 5'd0 && wrd == sb[0].instr[19:15]) begin
         sb[0].rs1 = wd;
      end
      if (iv && exp_ready) begin
         e.instr = ii;
         e.rs1   = operand(ii[19:15], wv, wrd, wd);
         sb.push_back(e);
      end
      if (wv && wrd != 5'd0) m_regs[wrd] = wd;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input logic ordy);
      tick(1'b0, 32'd0, ordy, 1'b0, 5'd0, 32'd0, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] held;
      bus.in_valid = 0; bus.in_instr = 0; bus.out_ready = 0;
      bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_data = 0; bus.flush = 0;
      model_reset();

      // Reset then idle
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_out_instr", bus.out_instr, 32'h0000_0013);
      check("rst_rs1",       bus.out_rs1_val, 32'd0);
      check("rst_rd",        {27'd0, bus.out_rd}, 32'd0);
      idle(1'b1);

      // Write then read
      tick(1'b0, 32'd0, 1'b1, 1'b1, 5'd5, 32'h0000_00AA, 1'b0);
      tick(1'b1, 32'h0032_8313, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
      check("wr_rd_rs1", bus.out_rs1_val, 32'h0000_00AA);
      check("wr_rd_rd",  {27'd0, bus.out_rd}, 32'd6);
      idle(1'b1);

      // Bypass, then the committed value
      tick(1'b1, addi(8, 7, 0), 1'b1, 1'b1, 5'd7, 32'h0000_1234, 1'b0);
      check("bypass_rs1", bus.out_rs1_val, 32'h0000_1234);
      tick(1'b1, addi(9, 7, 1), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
      check("x7_stored", bus.out_rs1_val, 32'h0000_1234);

      // x0 protection
      tick(1'b1, addi(1, 0, 5), 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
      tick(1'b1, addi(2, 0, 0), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
      check("x0_rs1", bus.out_rs1_val, 32'd0);
      idle(1'b1);

      // Stall update
      tick(1'b1, addi(3, 9, 0), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
      held = bus.out_instr;
      tick(1'b1, addi(4, 5, 0), 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      tick(1'b0, 32'd0, 1'b0, 1'b1, 5'd9, 32'h0000_BEEF, 1'b0);
      check("stall_instr", bus.out_instr, held);
      check("stall_rs1",   bus.out_rs1_val, 32'h0000_BEEF);
      idle(1'b1);

      // Flush while stalled, with a write that must still commit
      tick(1'b1, addi(11, 5, 0), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
      tick(1'b1, addi(12, 6, 0), 1'b0, 1'b1, 5'd10, 32'h0000_0055, 1'b1);
      check("flush_valid", {31'd0, bus.out_valid}, 32'd0);
      check("flush_instr", bus.out_instr, NOP_INSTR);
      tick(1'b1, addi(13, 10, 0), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
      // Flush while transferring
      tick(1'b1, addi(14, 5, 0), 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
      check("flush_xfer_instr", bus.out_instr, NOP_INSTR);

      // Random back-to-back traffic with writebacks and backpressure
      for (int i = 0; i < 40; i++) begin
         tick(($urandom_range(0, 3) != 0), addi(i % 32, $urandom_range(0, 12), i),
              ($urandom_range(0, 2) != 0), $urandom_range(0, 1) == 1,
              5'($urandom_range(0, 12)), $urandom, ($urandom_range(0, 15) == 0));
      end

      // Asynchronous reset in mid-cycle
      tick(1'b1, addi(15, 7, 0), 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", {31'd0, bus.out_valid}, 32'd0);
      check("arst_instr", bus.out_instr, NOP_INSTR);
      check("arst_rs1",   bus.out_rs1_val, 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick(1'b1, addi(1, 5, 0), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
      tick(1'b1, addi(2, 7, 0), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
      tick(1'b1, addi(3, 10, 0), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
      tick(1'b1, addi(4, 9, 0), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
      check("arst_x9", bus.out_rs1_val, 32'd0);
      idle(1'b1);
      idle(1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
